axil_kg_regfile: RTL and testbench

AXI4-Lite slave register file that holds a single byte-override command: a byte lane index, a byte value, and two valid flags. Its outputs drive the per-port byte-substitution logic in the Kugelblitz offload datapath. One instance exists per QSFP port, all on the AXI-Lite clock.

---
 rtl/axil_kg_regfile.sv | 149 ++++++++++++++
 tb/tb_axil_kg_regfile.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_kg_regfile.sv
// AXI4-Lite register file holding one Kugelblitz byte-override command
// (lane index, byte value, two enables) that feeds the per-port substitution logic.
module axil_kg_regfile #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int KG_ADDR_WIDTH = 6,
  parameter int KG_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic [2:0]               s_axil_awprot,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [DATA_WIDTH-1:0]    s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]    s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,

  input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [DATA_WIDTH-1:0]    s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,

  output logic [KG_ADDR_WIDTH-1:0] kg_address,
  output logic                     kg_address_valid,
  output logic [KG_DATA_WIDTH-1:0] kg_data,
  output logic                     kg_data_valid
);

  localparam logic [5:0]            SEL_ADDR = 6'd0;
  localparam logic [5:0]            SEL_DATA = 6'd1;
  localparam logic [5:0]            SEL_CTRL = 6'd2;
  localparam logic [5:0]            SEL_ID   = 6'd3;
  localparam logic [DATA_WIDTH-1:0] KG_ID    = 32'h4B47_0001;

  logic                     r_awready;
  logic                     r_bvalid;
  logic                     r_arready;
  logic                     r_rvalid;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [KG_ADDR_WIDTH-1:0] r_kg_address;
  logic [KG_DATA_WIDTH-1:0] r_kg_data;
  logic                     r_kg_address_valid;
  logic                     r_kg_data_valid;

  logic                     w_wr_hs;
  logic                     w_rd_hs;
  logic [5:0]               w_wr_sel;
  logic [5:0]               w_rd_sel;
  logic [DATA_WIDTH-1:0]    w_bmask;
  logic [KG_ADDR_WIDTH-1:0] w_addr_next;
  logic [KG_DATA_WIDTH-1:0] w_data_next;
  logic [DATA_WIDTH-1:0]    w_rd_data;
  logic                     w_unused;

  // Address bits outside [7:2], prot and upper data bits are intentionally aliased/ignored.
  assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr,
                      s_axil_wdata, w_bmask};

  assign w_wr_hs  = s_axil_awvalid && s_axil_wvalid && r_awready;
  assign w_rd_hs  = s_axil_arvalid && r_arready;
  assign w_wr_sel = s_axil_awaddr[7:2];
  assign w_rd_sel = s_axil_araddr[7:2];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) w_bmask[i] = s_axil_wstrb[i/8];
  end

  assign w_addr_next = (r_kg_address & ~w_bmask[KG_ADDR_WIDTH-1:0]) |
                       (s_axil_wdata[KG_ADDR_WIDTH-1:0] & w_bmask[KG_ADDR_WIDTH-1:0]);
  assign w_data_next = (r_kg_data & ~w_bmask[KG_DATA_WIDTH-1:0]) |
                       (s_axil_wdata[KG_DATA_WIDTH-1:0] & w_bmask[KG_DATA_WIDTH-1:0]);

  always_comb begin
    w_rd_data = '0;
    case (w_rd_sel)
      SEL_ADDR: w_rd_data[KG_ADDR_WIDTH-1:0] = r_kg_address;
      SEL_DATA: w_rd_data[KG_DATA_WIDTH-1:0] = r_kg_data;
      SEL_CTRL: w_rd_data[1:0] = {r_kg_data_valid, r_kg_address_valid};
      SEL_ID:   w_rd_data = KG_ID;
      default:  w_rd_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
  // this is also what makes a same-cycle read of a written register return the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_awready          <= 1'b0;
      r_bvalid           <= 1'b0;
      r_arready          <= 1'b0;
      r_rvalid           <= 1'b0;
      r_rdata            <= '0;
      r_kg_address       <= '0;
      r_kg_data          <= '0;
      r_kg_address_valid <= 1'b0;
      r_kg_data_valid    <= 1'b0;
    end else begin
      // awready/wready pulse one cycle after both channels are valid and the B slot is free.
      r_awready <= s_axil_awvalid && s_axil_wvalid && !r_awready && (!r_bvalid || s_axil_bready);
      if (r_bvalid && s_axil_bready) r_bvalid <= 1'b0;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        case (w_wr_sel)
          SEL_ADDR: r_kg_address <= w_addr_next;
          SEL_DATA: r_kg_data    <= w_data_next;
          SEL_CTRL: begin
            if (w_bmask[0]) r_kg_address_valid <= s_axil_wdata[0];
            if (w_bmask[1]) r_kg_data_valid    <= s_axil_wdata[1];
          end
          default: ;
        endcase
      end

      r_arready <= s_axil_arvalid && !r_arready && (!r_rvalid || s_axil_rready);
      if (r_rvalid && s_axil_rready) r_rvalid <= 1'b0;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end
    end
  end

  assign s_axil_awready   = r_awready;
  assign s_axil_wready    = r_awready;
  assign s_axil_bresp     = 2'b00;
  assign s_axil_bvalid    = r_bvalid;
  assign s_axil_arready   = r_arready;
  assign s_axil_rdata     = r_rdata;
  assign s_axil_rresp     = 2'b00;
  assign s_axil_rvalid    = r_rvalid;
  assign kg_address       = r_kg_address;
  assign kg_address_valid = r_kg_address_valid;
  assign kg_data          = r_kg_data;
  assign kg_data_valid    = r_kg_data_valid;

endmodule

// File: tb/tb_axil_kg_regfile.sv
// Self-checking bench for axil_kg_regfile: directed vector table, hand-written
// handshake/reset sequences, then random traffic against a field-level model.
module tb_axil_kg_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [31:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic [5:0]  kg_address;
  logic        kg_address_valid;
  logic [7:0]  kg_data;
  logic        kg_data_valid;

  localparam logic [31:0] ID_VAL = 32'h4B47_0001;

  int n_total = 0;
  int n_bad   = 0;

  axil_kg_regfile dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .kg_address(kg_address), .kg_address_valid(kg_address_valid),
    .kg_data(kg_data), .kg_data_valid(kg_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: handshake wait expired", name);
  endtask

  function automatic logic [31:0] kg_pack(input bit av, input bit dv, input logic [7:0] d,
                                          input logic [5:0] a);
    return {16'h0, av, dv, d, a};
  endfunction

  function automatic logic [31:0] kg_now();
    return {16'h0, kg_address_valid, kg_data_valid, kg_data, kg_address};
  endfunction

  // Returns at the negedge after the handshake edge, with valids dropped.
  task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    got = 1'b0;
    @(negedge clk);
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_awready) got = 1'b1;
    end
    if (!got) begin
      timeout("wr_accept");
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    end else begin
      check("wready_with_awready", {31'b0, s_axil_wready}, 32'd1);
      @(negedge clk);
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      check("bvalid_after_accept", {31'b0, s_axil_bvalid}, 32'd1);
      check("bresp_okay", {30'b0, s_axil_bresp}, 32'd0);
    end
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    d = 'x;
    @(negedge clk);
    s_axil_araddr = a; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_arready) got = 1'b1;
    end
    if (!got) begin
      timeout("rd_accept");
      s_axil_arvalid = 1'b0;
    end else begin
      @(negedge clk);
      s_axil_arvalid = 1'b0;
      check("rvalid_after_accept", {31'b0, s_axil_rvalid}, 32'd1);
      check("rresp_okay", {30'b0, s_axil_rresp}, 32'd0);
      d = s_axil_rdata;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;   // read data for reads, packed kg_* for writes
  } vec_t;

  vec_t vecs[$];

  // Reference model state: the four architectural fields.
  logic [5:0] m_a;
  logic [7:0] m_d;
  bit         m_av, m_dv;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[7:2])
      6'd0:    return {26'b0, m_a};
      6'd1:    return {24'b0, m_d};
      6'd2:    return {30'b0, m_dv, m_av};
      6'd3:    return ID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    bit          got;

    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
    s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_awready", {31'b0, s_axil_awready}, 32'd0);
    check("rst_bvalid", {31'b0, s_axil_bvalid}, 32'd0);
    check("rst_arready", {31'b0, s_axil_arready}, 32'd0);
    check("rst_rvalid", {31'b0, s_axil_rvalid}, 32'd0);
    check("rst_rdata", s_axil_rdata, 32'd0);
    check("rst_kg", kg_now(), 32'd0);

    // Directed table
    vecs.push_back('{0, 32'h00, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{0, 32'h04, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{0, 32'h08, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{0, 32'h0C, 32'h0, 4'h0, ID_VAL});
    vecs.push_back('{1, 32'h00, 32'h2A, 4'hF, kg_pack(0, 0, 8'h00, 6'h2A)});
    vecs.push_back('{1, 32'h04, 32'hA5, 4'hF, kg_pack(0, 0, 8'hA5, 6'h2A)});
    vecs.push_back('{1, 32'h08, 32'h3, 4'hF, kg_pack(1, 1, 8'hA5, 6'h2A)});
    vecs.push_back('{0, 32'h00, 32'h0, 4'h0, 32'h2A});
    vecs.push_back('{0, 32'h04, 32'h0, 4'h0, 32'hA5});
    vecs.push_back('{0, 32'h08, 32'h0, 4'h0, 32'h3});
    vecs.push_back('{1, 32'h04, 32'h1234, 4'h2, kg_pack(1, 1, 8'hA5, 6'h2A)});
    vecs.push_back('{1, 32'h04, 32'hFF, 4'h1, kg_pack(1, 1, 8'hFF, 6'h2A)});
    vecs.push_back('{1, 32'h0C, 32'hFFFF_FFFF, 4'hF, kg_pack(1, 1, 8'hFF, 6'h2A)});
    vecs.push_back('{1, 32'h40, 32'hFFFF_FFFF, 4'hF, kg_pack(1, 1, 8'hFF, 6'h2A)});
    vecs.push_back('{0, 32'h0C, 32'h0, 4'h0, ID_VAL});
    vecs.push_back('{0, 32'h40, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{0, 32'h04, 32'h0, 4'h0, 32'hFF});
    vecs.push_back('{1, 32'h103, 32'hFFFF_FF15, 4'hF, kg_pack(1, 1, 8'hFF, 6'h15)});
    vecs.push_back('{0, 32'hABCD_0201, 32'h0, 4'h0, 32'h15});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axil_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        check($sformatf("vec%0d_kg", i), kg_now(), vecs[i].exp);
      end else begin
        axil_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end
    end

    // Same-cycle read and write of DATA: read sees the pre-write value.
    @(negedge clk);
    s_axil_awaddr = 32'h04; s_axil_wdata = 32'h3C; s_axil_wstrb = 4'h1;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    s_axil_araddr = 32'h04; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_awready && s_axil_arready) got = 1'b1;
    end
    if (!got) timeout("rw_same_cycle_accept");
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    check("rw_same_rdata_old", s_axil_rdata, 32'hFF);
    check("rw_same_kg_data_new", {24'b0, kg_data}, 32'h3C);

    // AW ahead of W, then a second write held off while bvalid waits on bready.
    @(negedge clk);
    s_axil_awaddr = 32'h04; s_axil_wdata = 32'h5A; s_axil_wstrb = 4'h1;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("aw_only_no_accept%0d", n), {31'b0, s_axil_awready}, 32'd0);
    end
    s_axil_wvalid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_awready) got = 1'b1;
    end
    if (!got) timeout("aw_then_w_accept");
    @(negedge clk);
    s_axil_wdata = 32'h77;
    check("held_b_kg_data", {24'b0, kg_data}, 32'h5A);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("bpend_no_accept%0d", n), {31'b0, s_axil_awready}, 32'd0);
      check($sformatf("bpend_bvalid_held%0d", n), {31'b0, s_axil_bvalid}, 32'd1);
    end
    s_axil_bready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_awready) got = 1'b1;
    end
    if (!got) timeout("second_write_accept");
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    check("second_write_kg_data", {24'b0, kg_data}, 32'h77);
    check("second_write_bvalid", {31'b0, s_axil_bvalid}, 32'd1);
    @(negedge clk);
    check("bvalid_cleared", {31'b0, s_axil_bvalid}, 32'd0);

    // Reset with rvalid pending and a write on its accepting edge.
    @(negedge clk);
    s_axil_araddr = 32'h00; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_arready) got = 1'b1;
    end
    if (!got) timeout("pending_read_accept");
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    check("pending_rvalid", {31'b0, s_axil_rvalid}, 32'd1);
    s_axil_awaddr = 32'h04; s_axil_wdata = 32'h99; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_awready) got = 1'b1;
    end
    if (!got) timeout("write_before_reset_accept");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    check("midrst_rvalid", {31'b0, s_axil_rvalid}, 32'd0);
    check("midrst_bvalid", {31'b0, s_axil_bvalid}, 32'd0);
    check("midrst_kg", kg_now(), 32'd0);
    axil_read(32'h00, rd); check("midrst_rd_addr", rd, 32'h0);
    axil_read(32'h04, rd); check("midrst_rd_data", rd, 32'h0);
    axil_read(32'h08, rd); check("midrst_rd_ctrl", rd, 32'h0);

    // Random traffic against the field model (registers are all zero here).
    m_a = '0; m_d = '0; m_av = 1'b0; m_dv = 1'b0;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      int          off;
      off = $urandom_range(0, 5);
      if (off > 3) off = $urandom_range(4, 63);
      a = ($urandom & 32'hFFFF_FF00) | (32'(off) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        axil_write(a, d, s);
        if (s[0]) begin
          case (off)
            0: m_a = d[5:0];
            1: m_d = d[7:0];
            2: begin m_av = d[0]; m_dv = d[1]; end
            default: ;
          endcase
        end
        check($sformatf("rand%0d_kg", i), kg_now(), kg_pack(m_av, m_dv, m_d, m_a));
      end else begin
        axil_read(a, rd);
        check($sformatf("rand%0d_rdata", i), rd, model_read(a));
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
